// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bus plus the external 16-bit SRAM pins.
// The controller sits on the slave modport; the pipeline and the SRAM
// device together form the master side.
interface sram_mem_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage responder for a 16-bit external SRAM. Each 32-bit word moves as
// two half-word accesses (low half first), each held for WAIT_CYCLES clocks.
// ready is low while an access is pending so the pipeline can freeze.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access; a request is latched and starts the low half
// LOW   | low half on the SRAM bus ({idx,0}) for WAIT_CYCLES cycles
// HIGH  | high half on the SRAM bus ({idx,1}) for WAIT_CYCLES cycles
// DONE  | one cycle with ready=1 while the pipeline advances
module sram_mem_controller #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic clk,
  input  logic rst,
  sram_mem_controller_if.slave bus
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      wait_cnt;
  logic [SRAM_AW-2:0] idx_q;
  logic [15:0]        wdata_hi_q;
  logic               is_write_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [15:0]        dq_out_q;
  logic               dq_oe_q;
  logic               we_n_q;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] idx_next;
  logic               req;
  logic               wait_done;

  // Addresses below ADDR_BASE simply wrap; the word index is truncated to
  // the SRAM size.
  assign offset    = bus.address - ADDR_BASE;
  assign idx_next  = (SRAM_AW-1)'(offset >> 2);
  assign req       = bus.wr_en | bus.rd_en;
  assign wait_done = (wait_cnt == '0);

  // ready drops in the same cycle a request appears so the stall is immediate.
  assign bus.ready       = (state == DONE) || ((state == IDLE) && !req);
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;

  // Access sequencer: state, half-word wait timer and registered SRAM pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      idx_q       <= '0;
      wdata_hi_q  <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Write wins over read when both are requested.
            idx_q       <= idx_next;
            wdata_hi_q  <= bus.write_data[31:16];
            is_write_q  <= bus.wr_en;
            wait_cnt    <= CNT_LOAD;
            sram_addr_q <= {idx_next, 1'b0};
            dq_out_q    <= bus.write_data[15:0];
            we_n_q      <= ~bus.wr_en;
            dq_oe_q     <= bus.wr_en;
            state       <= LOW;
          end
        end
        LOW: begin
          if (wait_done) begin
            if (!is_write_q) read_data_q[15:0] <= bus.sram_dq_in;
            wait_cnt    <= CNT_LOAD;
            sram_addr_q <= {idx_q, 1'b1};
            dq_out_q    <= wdata_hi_q;
            state       <= HIGH;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        HIGH: begin
          if (wait_done) begin
            if (!is_write_q) read_data_q[31:16] <= bus.sram_dq_in;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: stimulus pushes expected SRAM addresses, write strobes and
// completion records; a negedge monitor pops and compares them. Instance a
// uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=1.
module tb_sram_mem_controller;
  localparam int SAW = 18;

  typedef struct { logic [31:0] rdata; int stall; } done_t;
  typedef struct { logic [SAW-1:0] addr; logic [15:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_mem_controller_if #(.SRAM_AW(SAW)) bus_a();
  sram_mem_controller_if #(.SRAM_AW(SAW)) bus_b();

  sram_mem_controller #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(SAW)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  sram_mem_controller #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(SAW)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  logic              rd_req [2];
  logic              wr_req [2];
  logic [31:0]       addr_req [2];
  logic [31:0]       wd_req [2];
  logic              ready_s [2];
  logic              oe_s [2];
  logic              we_n_s [2];
  logic [31:0]       rdata_s [2];
  logic [SAW-1:0]    saddr_s [2];
  logic [15:0]       dq_s [2];
  logic [15:0]       mem [2][262144];

  assign bus_a.rd_en      = rd_req[0];
  assign bus_a.wr_en      = wr_req[0];
  assign bus_a.address    = addr_req[0];
  assign bus_a.write_data = wd_req[0];
  assign bus_a.sram_dq_in = mem[0][bus_a.sram_addr];
  assign bus_b.rd_en      = rd_req[1];
  assign bus_b.wr_en      = wr_req[1];
  assign bus_b.address    = addr_req[1];
  assign bus_b.write_data = wd_req[1];
  assign bus_b.sram_dq_in = mem[1][bus_b.sram_addr];

  assign ready_s[0] = bus_a.ready;      assign ready_s[1] = bus_b.ready;
  assign oe_s[0]    = bus_a.sram_dq_oe; assign oe_s[1]    = bus_b.sram_dq_oe;
  assign we_n_s[0]  = bus_a.sram_we_n;  assign we_n_s[1]  = bus_b.sram_we_n;
  assign rdata_s[0] = bus_a.read_data;  assign rdata_s[1] = bus_b.read_data;
  assign saddr_s[0] = bus_a.sram_addr;  assign saddr_s[1] = bus_b.sram_addr;
  assign dq_s[0]    = bus_a.sram_dq_out; assign dq_s[1]   = bus_b.sram_dq_out;

  done_t          done_q [2][$];
  wr_t            wr_q [2][$];
  logic [SAW-1:0] addr_q [2][$];

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  bit prev_rdy [2] = '{1'b1, 1'b1};
  int stall [2]    = '{0, 0};

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void fail_now(input string nm, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h with no expectation pending", nm, act);
  endfunction

  // Monitor: compares SRAM addresses during LOW/HIGH, each write strobe, and
  // each completion (ready rising) against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        done_t e;
        wr_t   w;
        if (!ready_s[d]) begin
          stall[d] = stall[d] + 1;
          if (!prev_rdy[d]) begin
            if (addr_q[d].size() == 0) fail_now($sformatf("sram_addr_extra%0d", d), 32'(saddr_s[d]));
            else chk($sformatf("sram_addr%0d", d), 32'(saddr_s[d]), 32'(addr_q[d].pop_front()));
          end
        end else begin
          if (!prev_rdy[d]) begin
            if (done_q[d].size() == 0) fail_now($sformatf("done_extra%0d", d), rdata_s[d]);
            else begin
              e = done_q[d].pop_front();
              chk($sformatf("stall_len%0d", d), 32'(stall[d]), 32'(e.stall));
              chk($sformatf("read_data%0d", d), rdata_s[d], e.rdata);
            end
          end
          stall[d] = 0;
        end
        if (!we_n_s[d]) begin
          if (wr_q[d].size() == 0) fail_now($sformatf("we_n_extra%0d", d), 32'(saddr_s[d]));
          else begin
            w = wr_q[d].pop_front();
            chk($sformatf("wr_addr%0d", d), 32'(saddr_s[d]), 32'(w.addr));
            chk($sformatf("wr_dq%0d", d), 32'(dq_s[d]), 32'(w.data));
            chk($sformatf("wr_oe%0d", d), 32'(oe_s[d]), 32'd1);
          end
          mem[d][saddr_s[d]] = dq_s[d];
        end else begin
          chk($sformatf("oe_idle%0d", d), 32'(oe_s[d]), 32'd0);
        end
        prev_rdy[d] = ready_s[d];
      end
    end
  end

  task automatic push_exp(input int d, input bit w, input logic [SAW-1:0] lo,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
    int    wc;
    done_t e;
    wr_t   x;
    wc = (d == 0) ? 2 : 1;
    for (int k = 0; k < wc; k++) addr_q[d].push_back(lo);
    for (int k = 0; k < wc; k++) addr_q[d].push_back(lo + SAW'(1));
    if (w) begin
      for (int k = 0; k < wc; k++) begin x.addr = lo; x.data = wd[15:0]; wr_q[d].push_back(x); end
      for (int k = 0; k < wc; k++) begin x.addr = lo + SAW'(1); x.data = wd[31:16]; wr_q[d].push_back(x); end
    end
    e.rdata = exp_rd;
    e.stall = 2 * wc + 1;
    done_q[d].push_back(e);
  endtask

  task automatic drive(input int d, input bit w, input bit r, input logic [31:0] a, input logic [31:0] wd);
    wr_req[d] = w; rd_req[d] = r; addr_req[d] = a; wd_req[d] = wd;
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready_s[d] && n < 40);
    if (!ready_s[d]) begin
      n_total++;
      $display("FAIL timeout%0d: ready=%0b after %0d cycles, expected 1", d, ready_s[d], n);
    end
  endtask

  // One access, expected low-half SRAM address and read_data hand-computed.
  task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [SAW-1:0] lo, input logic [31:0] exp_rd);
    push_exp(d, w, lo, wd, exp_rd);
    drive(d, w, r, a, wd);
    wait_ready(d);
  endtask

  task automatic go_idle(input int d, input int cycles);
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_ready%0d", d), 32'(ready_s[d]), 32'd1);
      chk($sformatf("idle_we_n%0d", d), 32'(we_n_s[d]), 32'd1);
      chk($sformatf("idle_oe%0d", d), 32'(oe_s[d]), 32'd0);
    end
  endtask

  task automatic reset_checks(input int d);
    chk($sformatf("rst_read_data%0d", d), rdata_s[d], 32'd0);
    chk($sformatf("rst_we_n%0d", d), 32'(we_n_s[d]), 32'd1);
    chk($sformatf("rst_oe%0d", d), 32'(oe_s[d]), 32'd0);
    chk($sformatf("rst_sram_addr%0d", d), 32'(saddr_s[d]), 32'd0);
    chk($sformatf("rst_dq_out%0d", d), 32'(dq_s[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 262144; i++) mem[d][i] = 16'h0000;
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    mem[0][2] = 16'h3333; mem[0][3] = 16'h4444;
    mem[1][8] = 16'hCAFE; mem[1][9] = 16'hF00D;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks(0);
    reset_checks(1);
    chk("rst_ready0", 32'(ready_s[0]), 32'd1);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Write 0xDEADBEEF @1024 -> halves at SRAM 0 and 1
    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0000_0000);
    go_idle(0, 2);
    // Read it back
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
    go_idle(0, 1);
    // Back-to-back read 1028 (SRAM 2,3) then write 1032 (SRAM 4,5)
    access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'h44443333);
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 18'd4, 32'h44443333);
    go_idle(0, 1);
    // Read and write together -> write at SRAM 6,7, read_data untouched
    access(0, 1'b1, 1'b1, 32'd1036, 32'h13572468, 18'd6, 32'h44443333);
    go_idle(0, 20);

    // Reset during the second HIGH cycle of a write to 1024
    push_exp(0, 1'b1, 18'd0, 32'h12345678, 32'h44443333);
    drive(0, 1'b1, 1'b0, 32'd1024, 32'h12345678);
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_we_n", 32'(we_n_s[0]), 32'd1);
    chk("midrst_oe", 32'(oe_s[0]), 32'd0);
    chk("midrst_read_data", rdata_s[0], 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    addr_q[0].delete(); wr_q[0].delete(); done_q[0].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    prev_rdy[0] = 1'b1;
    stall[0] = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    // Low half and first high-half strobe landed before reset
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h12345678);
    go_idle(0, 1);

    // WAIT_CYCLES=1 instance: 3-cycle stall
    access(1, 1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'hF00DCAFE);
    go_idle(1, 1);
    // Address below base wraps to the top of the SRAM
    access(1, 1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 32'hF00DCAFE);
    go_idle(1, 1);
    access(1, 1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'hA5A55A5A);
    go_idle(1, 3);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("addr_q_left%0d", d), 32'(addr_q[d].size()), 32'd0);
      chk($sformatf("wr_q_left%0d", d), 32'(wr_q[d].size()), 32'd0);
      chk($sformatf("done_q_left%0d", d), 32'(done_q[d].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
